// File: rtl/fft_bin_peak_detect.sv
// Streaming post-processor for a serial FFT bin stream: alpha-max-plus-beta-min
// magnitude per bin, plus a per-frame peak report with framing-error detection.
module fft_bin_peak_detect #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SEQ_LENGTH = 16,
    parameter bit          SKIP_DC    = 1'b1,
    localparam int unsigned IW        = $clog2(SEQ_LENGTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] bin_real,
    input  logic signed [DATA_WIDTH-1:0] bin_img,
    input  logic                         bin_valid,
    input  logic                         bin_last,
    output logic        [DATA_WIDTH:0]   mag_out,
    output logic        [IW-1:0]         mag_index,
    output logic                         mag_valid,
    output logic        [DATA_WIDTH:0]   peak_mag,
    output logic        [IW-1:0]         peak_index,
    output logic                         peak_valid,
    output logic                         frame_error,
    output logic                         busy
);

    localparam int unsigned MW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ACCUM       = 2'd1,
        ST_REPORT_WAIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       bin_cnt;
    logic [IW-1:0]       bin_cnt_next;
    logic                at_end_c;
    logic                good_last_c;
    logic                frame_err_c;

    logic [DATA_WIDTH-1:0] re_u_c;
    logic [DATA_WIDTH-1:0] im_u_c;
    logic [DATA_WIDTH-1:0] abs_re_c;
    logic [DATA_WIDTH-1:0] abs_im_c;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_abs_re;
    logic [DATA_WIDTH-1:0] s1_abs_im;
    logic [IW-1:0]         s1_idx;
    logic                  s1_good_last;

    logic [DATA_WIDTH-1:0] max_c;
    logic [DATA_WIDTH-1:0] min_c;
    logic [MW-1:0]         mag_c;
    logic                  s2_good_last;

    logic [MW-1:0]         run_mag;
    logic [IW-1:0]         run_idx;
    logic [MW-1:0]         cand_mag_c;
    logic [IW-1:0]         cand_idx_c;

    assign at_end_c = (bin_cnt == IW'(SEQ_LENGTH - 1));

    // Input framing state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bin_cnt <= '0;
        end else begin
            state   <= state_next;
            bin_cnt <= bin_cnt_next;
        end
    end

    // Next-state logic; a bin is never stalled, so every valid bin decides the state
    always_comb begin
        state_next = state;
        if (bin_valid) begin
            if (bin_last && at_end_c) begin
                state_next = ST_REPORT_WAIT;
            end else if (bin_last || at_end_c) begin
                state_next = ST_IDLE;
            end else begin
                state_next = ST_ACCUM;
            end
        end else if ((state == ST_REPORT_WAIT) && peak_valid) begin
            state_next = ST_IDLE;
        end
    end

    // Framing decode: good-last tag, framing violation, bin counter update
    always_comb begin
        good_last_c  = 1'b0;
        frame_err_c  = 1'b0;
        bin_cnt_next = bin_cnt;
        if (bin_valid) begin
            good_last_c  = bin_last && at_end_c;
            frame_err_c  = bin_last ^ at_end_c;
            bin_cnt_next = (bin_last || at_end_c) ? '0 : bin_cnt + IW'(1);
        end
    end

    // Two's-complement magnitude; the most negative value maps to 2^(W-1)
    always_comb begin
        re_u_c   = bin_real;
        im_u_c   = bin_img;
        abs_re_c = re_u_c[DATA_WIDTH-1] ? (~re_u_c + DATA_WIDTH'(1)) : re_u_c;
        abs_im_c = im_u_c[DATA_WIDTH-1] ? (~im_u_c + DATA_WIDTH'(1)) : im_u_c;
    end

    always_comb begin
        max_c = (s1_abs_re >= s1_abs_im) ? s1_abs_re : s1_abs_im;
        min_c = (s1_abs_re >= s1_abs_im) ? s1_abs_im : s1_abs_re;
        mag_c = MW'(max_c) + MW'(min_c >> 1);
    end

    // Peak candidate: index 0 restarts the search, later bins need a strict win
    always_comb begin
        cand_mag_c = run_mag;
        cand_idx_c = run_idx;
        if (mag_index == '0) begin
            cand_mag_c = SKIP_DC ? '0 : mag_out;
            cand_idx_c = '0;
        end else if (mag_out > run_mag) begin
            cand_mag_c = mag_out;
            cand_idx_c = mag_index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_abs_re    <= '0;
            s1_abs_im    <= '0;
            s1_idx       <= '0;
            s1_good_last <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s1_valid     <= bin_valid;
            s1_good_last <= good_last_c;
            frame_error  <= frame_err_c;
            busy         <= bin_valid || s1_valid || (state_next != ST_IDLE);
            if (bin_valid) begin
                s1_abs_re <= abs_re_c;
                s1_abs_im <= abs_im_c;
                s1_idx    <= bin_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_valid    <= 1'b0;
            mag_out      <= '0;
            mag_index    <= '0;
            s2_good_last <= 1'b0;
        end else begin
            mag_valid    <= s1_valid;
            s2_good_last <= s1_valid && s1_good_last;
            if (s1_valid) begin
                mag_out   <= mag_c;
                mag_index <= s1_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_mag    <= '0;
            run_idx    <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= mag_valid && s2_good_last;
            if (mag_valid) begin
                run_mag <= cand_mag_c;
                run_idx <= cand_idx_c;
                if (s2_good_last) begin
                    peak_mag   <= cand_mag_c;
                    peak_index <= cand_idx_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bin_peak_detect.sv
// Directed bench for fft_bin_peak_detect: impulse, extremes, DC/ties, framing,
// streaming and mid-frame reset, with a second instance built with SKIP_DC=0.
module tb_fft_bin_peak_detect;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] bin_real = '0;
    logic signed [15:0] bin_img = '0;
    logic               bin_valid = 1'b0;
    logic               bin_last = 1'b0;

    logic [16:0] mag_out, peak_mag, nd_mag_out, nd_peak_mag;
    logic [3:0]  mag_index, peak_index, nd_mag_index, nd_peak_index;
    logic        mag_valid, peak_valid, frame_error, busy;
    logic        nd_mag_valid, nd_peak_valid, nd_frame_error, nd_busy;

    fft_bin_peak_detect #(.DATA_WIDTH(16), .SEQ_LENGTH(16), .SKIP_DC(1'b1)) dut (
        .clk(clk), .reset(reset), .bin_real(bin_real), .bin_img(bin_img),
        .bin_valid(bin_valid), .bin_last(bin_last),
        .mag_out(mag_out), .mag_index(mag_index), .mag_valid(mag_valid),
        .peak_mag(peak_mag), .peak_index(peak_index), .peak_valid(peak_valid),
        .frame_error(frame_error), .busy(busy)
    );

    fft_bin_peak_detect #(.DATA_WIDTH(16), .SEQ_LENGTH(16), .SKIP_DC(1'b0)) dut_nodc (
        .clk(clk), .reset(reset), .bin_real(bin_real), .bin_img(bin_img),
        .bin_valid(bin_valid), .bin_last(bin_last),
        .mag_out(nd_mag_out), .mag_index(nd_mag_index), .mag_valid(nd_mag_valid),
        .peak_mag(nd_peak_mag), .peak_index(nd_peak_index), .peak_valid(nd_peak_valid),
        .frame_error(nd_frame_error), .busy(nd_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mq_mag[$], mq_idx[$], mq_cyc[$];
    int pk_mag[$], pk_idx[$], pk_cyc[$];
    int nd_mag[$], nd_idx[$];
    int err_cyc[$];

    always @(negedge clk) begin
        if (mag_valid) begin
            mq_mag.push_back(int'(mag_out));
            mq_idx.push_back(int'(mag_index));
            mq_cyc.push_back(cyc);
        end
        if (peak_valid) begin
            pk_mag.push_back(int'(peak_mag));
            pk_idx.push_back(int'(peak_index));
            pk_cyc.push_back(cyc);
        end
        if (nd_peak_valid) begin
            nd_mag.push_back(int'(nd_peak_mag));
            nd_idx.push_back(int'(nd_peak_index));
        end
        if (frame_error) err_cyc.push_back(cyc);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic signed [15:0] fr_re[16];
    logic signed [15:0] fr_im[16];
    int                 bin_cyc[16];
    logic signed [15:0] st_re[64];
    logic signed [15:0] st_im[64];

    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im, input logic last);
        @(posedge clk);
        #1;
        bin_real  = re;
        bin_img   = im;
        bin_last  = last;
        bin_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bin_valid = 1'b0;
            bin_last  = 1'b0;
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic clear_logs();
        mq_mag.delete(); mq_idx.delete(); mq_cyc.delete();
        pk_mag.delete(); pk_idx.delete(); pk_cyc.delete();
        nd_mag.delete(); nd_idx.delete(); err_cyc.delete();
    endtask

    task automatic send_frame(input int nbins, input bit last_ok, input bit gaps);
        for (int i = 0; i < nbins; i++) begin
            send(fr_re[i], fr_im[i], last_ok && (i == nbins - 1));
            bin_cyc[i] = cyc;
            if (gaps && i < nbins - 1) idle(int'($urandom_range(1, 3)));
        end
    endtask

    function automatic int ref_mag(input logic signed [15:0] re, input logic signed [15:0] im);
        int a, b;
        a = int'(re);
        b = int'(im);
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return (a > b) ? (a + b / 2) : (b + a / 2);
    endfunction

    task automatic ref_peak(input int f, input bit skip, output int pm, output int pi);
        pm = skip ? 0 : ref_mag(st_re[16*f], st_im[16*f]);
        pi = 0;
        for (int i = 1; i < 16; i++) begin
            if (ref_mag(st_re[16*f+i], st_im[16*f+i]) > pm) begin
                pm = ref_mag(st_re[16*f+i], st_im[16*f+i]);
                pi = i;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mag_out"}, int'(mag_out), 0);
        chk({tag, "_mag_index"}, int'(mag_index), 0);
        chk({tag, "_mag_valid"}, int'(mag_valid), 0);
        chk({tag, "_peak_mag"}, int'(peak_mag), 0);
        chk({tag, "_peak_index"}, int'(peak_index), 0);
        chk({tag, "_peak_valid"}, int'(peak_valid), 0);
        chk({tag, "_frame_error"}, int'(frame_error), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pm, pi, bad_seq, bad_mag;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        // Impulse at bin 5
        clear_logs(); clear_frame();
        fr_re[5] = 16'sd1000; fr_im[5] = -16'sd500;
        send_frame(16, 1'b1, 1'b0);
        idle(8);
        chk("imp_mag_cnt", mq_mag.size(), 16);
        if (mq_mag.size() == 16) begin
            chk("imp_mag5", mq_mag[5], 1250);
            chk("imp_idx5", mq_idx[5], 5);
            chk("imp_mag_lat", mq_cyc[5] - bin_cyc[5], 2);
            chk("imp_mag4", mq_mag[4], 0);
        end
        chk("imp_pk_cnt", pk_mag.size(), 1);
        if (pk_mag.size() == 1) begin
            chk("imp_pk_idx", pk_idx[0], 5);
            chk("imp_pk_mag", pk_mag[0], 1250);
            chk("imp_pk_lat", pk_cyc[0] - bin_cyc[15], 3);
        end
        chk("imp_err_cnt", err_cyc.size(), 0);
        @(negedge clk);
        chk("imp_hold_mag", int'(peak_mag), 1250);
        chk("imp_hold_idx", int'(peak_index), 5);
        chk("imp_busy_idle", int'(busy), 0);

        // Extremes: most negative components versus full-scale real
        clear_logs(); clear_frame();
        fr_re[3] = -16'sd32768; fr_im[3] = -16'sd32768;
        fr_re[7] = 16'sd32767;
        send_frame(16, 1'b1, 1'b0);
        idle(8);
        if (mq_mag.size() == 16) begin
            chk("ext_mag3", mq_mag[3], 49152);
            chk("ext_mag7", mq_mag[7], 32767);
        end
        chk("ext_pk_cnt", pk_mag.size(), 1);
        if (pk_mag.size() == 1) begin
            chk("ext_pk_idx", pk_idx[0], 3);
            chk("ext_pk_mag", pk_mag[0], 49152);
        end

        // DC and ties
        clear_logs(); clear_frame();
        fr_re[0] = 16'sd20000;
        fr_im[2] = 16'sd400;
        fr_im[9] = 16'sd400;
        send_frame(16, 1'b1, 1'b0);
        idle(8);
        chk("dc_pk_cnt", pk_mag.size(), 1);
        if (pk_mag.size() == 1) begin
            chk("dc_pk_idx", pk_idx[0], 2);
            chk("dc_pk_mag", pk_mag[0], 400);
        end
        chk("nodc_pk_cnt", nd_mag.size(), 1);
        if (nd_mag.size() == 1) begin
            chk("nodc_pk_idx", nd_idx[0], 0);
            chk("nodc_pk_mag", nd_mag[0], 20000);
        end

        // Short frame: bin_last on the 10th bin
        clear_logs(); clear_frame();
        fr_re[4] = 16'sd100; fr_im[4] = 16'sd100;
        send_frame(10, 1'b1, 1'b0);
        idle(6);
        chk("short_err_cnt", err_cyc.size(), 1);
        if (err_cyc.size() == 1) chk("short_err_lat", err_cyc[0] - bin_cyc[9], 1);
        chk("short_pk_cnt", pk_mag.size(), 0);
        chk("short_mag_cnt", mq_mag.size(), 10);
        if (mq_mag.size() == 10) begin
            chk("short_mag4", mq_mag[4], 150);
            chk("short_idx9", mq_idx[9], 9);
        end

        // Clean frame after the short one
        clear_logs(); clear_frame();
        fr_re[6] = -16'sd300; fr_im[6] = 16'sd200;
        send_frame(16, 1'b1, 1'b0);
        idle(8);
        chk("recov_pk_cnt", pk_mag.size(), 1);
        if (pk_mag.size() == 1) begin
            chk("recov_pk_idx", pk_idx[0], 6);
            chk("recov_pk_mag", pk_mag[0], 400);
        end
        chk("recov_err_cnt", err_cyc.size(), 0);

        // Missing last: 16 bins without bin_last
        clear_logs(); clear_frame();
        fr_re[15] = 16'sd7;
        send_frame(16, 1'b0, 1'b0);
        idle(6);
        chk("miss_err_cnt", err_cyc.size(), 1);
        if (err_cyc.size() == 1) chk("miss_err_lat", err_cyc[0] - bin_cyc[15], 1);
        chk("miss_pk_cnt", pk_mag.size(), 0);

        // Streaming: three contiguous frames, then one with gaps
        for (int k = 0; k < 64; k++) begin
            st_re[k] = 16'($urandom);
            st_im[k] = 16'($urandom);
        end
        st_re[20] = -16'sd32768;
        clear_logs();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                fr_re[i] = st_re[16*f+i];
                fr_im[i] = st_im[16*f+i];
            end
            send_frame(16, 1'b1, f == 3);
        end
        idle(10);
        chk("strm_pk_cnt", pk_mag.size(), 4);
        chk("strm_nodc_cnt", nd_mag.size(), 4);
        chk("strm_err_cnt", err_cyc.size(), 0);
        if (pk_mag.size() == 4) begin
            for (int f = 0; f < 4; f++) begin
                ref_peak(f, 1'b1, pm, pi);
                chk($sformatf("strm_pk_mag%0d", f), pk_mag[f], pm);
                chk($sformatf("strm_pk_idx%0d", f), pk_idx[f], pi);
            end
            chk("strm_period01", pk_cyc[1] - pk_cyc[0], 16);
            chk("strm_period12", pk_cyc[2] - pk_cyc[1], 16);
        end
        if (nd_mag.size() == 4) begin
            for (int f = 0; f < 4; f++) begin
                ref_peak(f, 1'b0, pm, pi);
                chk($sformatf("strm_nodc_mag%0d", f), nd_mag[f], pm);
                chk($sformatf("strm_nodc_idx%0d", f), nd_idx[f], pi);
            end
        end
        chk("strm_mag_cnt", mq_mag.size(), 64);
        if (mq_mag.size() == 64) begin
            bad_seq = 0;
            bad_mag = 0;
            for (int k = 0; k < 64; k++) begin
                if (mq_idx[k] != k % 16) bad_seq++;
                if (mq_mag[k] != ref_mag(st_re[k], st_im[k])) bad_mag++;
            end
            chk("strm_idx_seq_bad", bad_seq, 0);
            chk("strm_mag_bad", bad_mag, 0);
        end

        // Reset for one cycle in place of bin 8, then a full frame
        clear_logs(); clear_frame();
        fr_re[2] = 16'sd30000;
        send_frame(8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_all_zero("mrst_a");
        @(negedge clk);
        chk_all_zero("mrst_b");
        clear_frame();
        fr_re[12] = 16'sd500; fr_im[12] = 16'sd500;
        send_frame(16, 1'b1, 1'b0);
        idle(8);
        chk("mrst_pk_cnt", pk_mag.size(), 1);
        if (pk_mag.size() == 1) begin
            chk("mrst_pk_idx", pk_idx[0], 12);
            chk("mrst_pk_mag", pk_mag[0], 750);
        end
        chk("mrst_err_cnt", err_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
